// File: rtl/rst_req_pkg.sv
// Shared types and helpers for the reset-request initiator.
// The state encoding, the cause bit positions and the counter sizing rule
// are defined here so that the top level and the counter agree on them.
package rst_req_pkg;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ASSERT    = 2'd1,
      WAIT_DONE = 2'd2,
      HOLDOFF   = 2'd3
   } rst_req_state_e;

   // Bit positions inside a cause vector, read as {dbg, wdog, sw}.
   localparam int unsigned CauseSw   = 32'd0;
   localparam int unsigned CauseWdog = 32'd1;
   localparam int unsigned CauseDbg  = 32'd2;
   localparam int unsigned CauseW    = 32'd3;

   typedef logic [CauseW-1:0] rst_cause_t;

   // Largest of three cycle counts.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

   // Width of a counter that must be able to hold the largest load value.
   function automatic int unsigned cnt_width(input int unsigned assert_cycles,
                                             input int unsigned holdoff_cycles,
                                             input int unsigned timeout_cycles);
      return $clog2(max3(assert_cycles, holdoff_cycles, timeout_cycles) + 32'd1);
   endfunction

   // Gathers the three request inputs into a cause-shaped vector.
   function automatic rst_cause_t pack_req(input logic sw,
                                           input logic wdog,
                                           input logic dbg);
      rst_cause_t c;
      c            = {CauseW{1'b0}};
      c[CauseSw]   = sw;
      c[CauseWdog] = wdog;
      c[CauseDbg]  = dbg;
      return c;
   endfunction

endpackage

// File: rtl/rst_req_cnt.sv
// Loadable saturating down-counter used for every timed phase of the
// reset-request sequencer (assert width, hold-off window, release timeout).
// Priority: clear, then load, then count down; it stops at zero.
module rst_req_cnt #(
   parameter int unsigned Width = 32'd4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [Width-1:0] value_i,
   output logic             zero_o
);

   localparam logic [Width-1:0] CntZero = {Width{1'b0}};
   localparam logic [Width-1:0] CntOne  = Width'(1'b1);

   logic [Width-1:0] cnt_d;
   logic [Width-1:0] cnt_q;

   // Next count: clear, load, or step down toward zero without wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = CntZero;
      end else if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != CntZero) begin
         cnt_d = cnt_q - CntOne;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= CntZero;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == CntZero);

endmodule

// File: rtl/rst_req_gen.sv
// Reset-request initiator for the always-on reset synchronizers.
// Merges software, watchdog and debug requests into one active-low request
// pulse of fixed width, waits for the downstream synchronizer to report a
// fresh release, then keeps a hold-off window before the next sequence.
// Requests that arrive while a sequence is finishing are kept as pending
// bits and start the next sequence once the block is idle again.
//
// Optional feature: define RST_REQ_GEN_TIMEOUT_EN to bound the wait for the
// release indication; on expiry the sticky timeout_o flag is raised and the
// sequence moves on to the hold-off window. Without it timeout_o stays 0
// and the wait is unbounded.
module rst_req_gen
   import rst_req_pkg::*;
#(
   parameter int unsigned AssertCycles  = 32'd16,
   parameter int unsigned HoldOffCycles = 32'd8,
   parameter int unsigned TimeoutCycles = 32'd1024
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sw_req_i,
   input  logic       wdog_req_i,
   input  logic       dbg_req_i,
   input  logic       rst_done_i,
   output logic       rst_req_no,
   output logic       busy_o,
   output logic [2:0] cause_o,
   output logic       timeout_o
);

   localparam int unsigned CntW = cnt_width(AssertCycles, HoldOffCycles, TimeoutCycles);

   // The counter is loaded one below the phase length because the load
   // happens on the transition edge and the phase ends on the zero cycle.
   // A zero-length hold-off still occupies one cycle.
   localparam logic [CntW-1:0] AssertLoad  = CntW'(AssertCycles - 32'd1);
   localparam logic [CntW-1:0] HoldOffLoad = CntW'((HoldOffCycles == 32'd0) ?
                                                   32'd0 : (HoldOffCycles - 32'd1));
`ifdef RST_REQ_GEN_TIMEOUT_EN
   localparam logic [CntW-1:0] TimeoutLoad = CntW'(TimeoutCycles - 32'd1);
`endif

   localparam rst_cause_t CauseNone = {CauseW{1'b0}};

   rst_req_state_e state_d, state_q;
   rst_cause_t     cause_d, cause_q;
   rst_cause_t     pending_d, pending_q;
   logic           seen_low_d, seen_low_q;
   logic           timeout_d, timeout_q;
   logic           rst_req_n_d, rst_req_n_q;
   logic           busy_d, busy_q;

   rst_cause_t      req_s;
   logic            cnt_clr_s;
   logic            cnt_load_s;
   logic [CntW-1:0] cnt_value_s;
   logic            cnt_zero_s;

   // Shared phase counter.
   rst_req_cnt #(
      .Width (CntW)
   ) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (cnt_clr_s),
      .load_i  (cnt_load_s),
      .value_i (cnt_value_s),
      .zero_o  (cnt_zero_s)
   );

   // Collect the request inputs into cause bit order.
   always_comb begin
      req_s = pack_req(sw_req_i, wdog_req_i, dbg_req_i);
   end

   // Sequencer next state, cause/pending bookkeeping and counter control.
   always_comb begin
      state_d     = state_q;
      cause_d     = cause_q;
      pending_d   = pending_q;
      seen_low_d  = seen_low_q;
      timeout_d   = timeout_q;
      cnt_clr_s   = 1'b0;
      cnt_load_s  = 1'b0;
      cnt_value_s = {CntW{1'b0}};

      case (state_q)
         IDLE: begin
            if ((req_s | pending_q) != CauseNone) begin
               state_d     = ASSERT;
               cause_d     = req_s | pending_q;
               pending_d   = CauseNone;
               seen_low_d  = 1'b0;
               cnt_load_s  = 1'b1;
               cnt_value_s = AssertLoad;
            end else begin
               state_d = IDLE;
            end
         end

         ASSERT: begin
            // Late requests join the running sequence instead of queueing.
            cause_d = cause_q | req_s;
            if (!rst_done_i) begin
               seen_low_d = 1'b1;
            end else begin
               seen_low_d = seen_low_q;
            end
            if (cnt_zero_s) begin
               state_d = WAIT_DONE;
`ifdef RST_REQ_GEN_TIMEOUT_EN
               cnt_load_s  = 1'b1;
               cnt_value_s = TimeoutLoad;
`endif
            end else begin
               state_d = ASSERT;
            end
         end

         WAIT_DONE: begin
            pending_d = pending_q | req_s;
            if (!rst_done_i) begin
               seen_low_d = 1'b1;
            end else begin
               seen_low_d = seen_low_q;
            end
            // Only a release that follows an observed low counts; a level
            // left high from the previous epoch is not a release.
            if (seen_low_q && rst_done_i) begin
               state_d     = HOLDOFF;
               cnt_load_s  = 1'b1;
               cnt_value_s = HoldOffLoad;
`ifdef RST_REQ_GEN_TIMEOUT_EN
            end else if (cnt_zero_s) begin
               state_d     = HOLDOFF;
               timeout_d   = 1'b1;
               cnt_load_s  = 1'b1;
               cnt_value_s = HoldOffLoad;
`endif
            end else begin
               state_d = WAIT_DONE;
            end
         end

         HOLDOFF: begin
            pending_d = pending_q | req_s;
            if (cnt_zero_s) begin
               state_d   = IDLE;
               cnt_clr_s = 1'b1;
            end else begin
               state_d = HOLDOFF;
            end
         end

         default: begin
            state_d   = IDLE;
            cnt_clr_s = 1'b1;
         end
      endcase
   end

   // Output values derived from the next state so the outputs are flops.
   always_comb begin
      rst_req_n_d = (state_d != ASSERT);
      busy_d      = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cause_q     <= CauseNone;
         pending_q   <= CauseNone;
         seen_low_q  <= 1'b0;
         timeout_q   <= 1'b0;
         rst_req_n_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_q     <= cause_d;
         pending_q   <= pending_d;
         seen_low_q  <= seen_low_d;
         timeout_q   <= timeout_d;
         rst_req_n_q <= rst_req_n_d;
         busy_q      <= busy_d;
      end
   end

   assign rst_req_no = rst_req_n_q;
   assign busy_o     = busy_q;
   assign cause_o    = cause_q;
   // Without the timeout feature nothing ever sets this flop, so it holds 0.
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// Directed bench for rst_req_gen (AssertCycles=16, HoldOffCycles=8,
// TimeoutCycles=32). A table of {inputs, cycle count, expected outputs}
// rows is replayed cycle by cycle; a hand-written sequence covers the
// release-never-seen case, which depends on RST_REQ_GEN_TIMEOUT_EN.
module tb_rst_req_gen;

   localparam int unsigned A = 32'd16;
   localparam int unsigned H = 32'd8;
   localparam int unsigned T = 32'd32;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       sw_req_i;
   logic       wdog_req_i;
   logic       dbg_req_i;
   logic       rst_done_i;
   logic       rst_req_no;
   logic       busy_o;
   logic [2:0] cause_o;
   logic       timeout_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         n;
      logic       rst;
      logic       sw;
      logic       wdog;
      logic       dbg;
      logic       done;
      logic       exp_req_n;
      logic       exp_busy;
      logic [2:0] exp_cause;
   } vec_t;

   vec_t vecs[$];

   rst_req_gen #(
      .AssertCycles  (A),
      .HoldOffCycles (H),
      .TimeoutCycles (T)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sw_req_i   (sw_req_i),
      .wdog_req_i (wdog_req_i),
      .dbg_req_i  (dbg_req_i),
      .rst_done_i (rst_done_i),
      .rst_req_no (rst_req_no),
      .busy_o     (busy_o),
      .cause_o    (cause_o),
      .timeout_o  (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input int row, input int cyc,
                      input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d cycle %0d: got %b expected %b", nm, row, cyc, act, exp);
      end
   endtask

   task automatic chk_all(input int row, input int cyc, input logic rn, input logic b,
                          input logic [2:0] c, input logic t);
      chk("rst_req_no", row, cyc, {2'b00, rst_req_no}, {2'b00, rn});
      chk("busy_o",     row, cyc, {2'b00, busy_o},     {2'b00, b});
      chk("cause_o",    row, cyc, cause_o,             c);
      chk("timeout_o",  row, cyc, {2'b00, timeout_o},  {2'b00, t});
   endtask

   function automatic vec_t v(input int n, input logic r, input logic s, input logic w,
                              input logic d, input logic dn, input logic rn,
                              input logic b, input logic [2:0] c);
      vec_t x;
      x.n = n; x.rst = r; x.sw = s; x.wdog = w; x.dbg = d; x.done = dn;
      x.exp_req_n = rn; x.exp_busy = b; x.exp_cause = c;
      return x;
   endfunction

   initial begin
      rst_i = 1'b1; sw_req_i = 1'b0; wdog_req_i = 1'b0; dbg_req_i = 1'b0; rst_done_i = 1'b1;

      //             n  rst sw wd db done  req_n busy cause
      // reset, idle, single sw pulse with a well-behaved release
      vecs.push_back(v( 2, 1, 0, 0, 0, 1,   1, 0, 3'b000));
      vecs.push_back(v( 3, 0, 0, 0, 0, 1,   1, 0, 3'b000));
      vecs.push_back(v( 1, 0, 1, 0, 0, 1,   0, 1, 3'b001));
      vecs.push_back(v(15, 0, 0, 0, 0, 0,   0, 1, 3'b001));
      vecs.push_back(v( 1, 0, 0, 0, 0, 0,   1, 1, 3'b001));
      vecs.push_back(v( 1, 0, 0, 0, 0, 1,   1, 1, 3'b001));
      vecs.push_back(v( 7, 0, 0, 0, 0, 1,   1, 1, 3'b001));
      vecs.push_back(v( 2, 0, 0, 0, 0, 1,   1, 0, 3'b001));
      // wdog+dbg together; done stays high (stale) until a low is seen
      vecs.push_back(v( 1, 0, 0, 1, 1, 1,   0, 1, 3'b110));
      vecs.push_back(v(15, 0, 0, 0, 0, 1,   0, 1, 3'b110));
      vecs.push_back(v(10, 0, 0, 0, 0, 1,   1, 1, 3'b110));
      vecs.push_back(v( 1, 0, 0, 0, 0, 0,   1, 1, 3'b110));
      vecs.push_back(v( 1, 0, 0, 0, 0, 1,   1, 1, 3'b110));
      vecs.push_back(v( 7, 0, 0, 0, 0, 1,   1, 1, 3'b110));
      vecs.push_back(v( 2, 0, 0, 0, 0, 1,   1, 0, 3'b110));
      // sw, wdog joins in ASSERT, dbg in WAIT_DONE and again in HOLDOFF
      vecs.push_back(v( 1, 0, 1, 0, 0, 1,   0, 1, 3'b001));
      vecs.push_back(v( 1, 0, 0, 1, 0, 0,   0, 1, 3'b011));
      vecs.push_back(v(14, 0, 0, 0, 0, 0,   0, 1, 3'b011));
      vecs.push_back(v( 1, 0, 0, 0, 0, 0,   1, 1, 3'b011));
      vecs.push_back(v( 1, 0, 0, 0, 1, 0,   1, 1, 3'b011));
      vecs.push_back(v( 1, 0, 0, 0, 0, 1,   1, 1, 3'b011));
      vecs.push_back(v( 1, 0, 0, 0, 1, 1,   1, 1, 3'b011));
      vecs.push_back(v( 6, 0, 0, 0, 0, 1,   1, 1, 3'b011));
      vecs.push_back(v( 1, 0, 0, 0, 0, 1,   1, 0, 3'b011));
      vecs.push_back(v( 1, 0, 0, 0, 0, 1,   0, 1, 3'b100));
      vecs.push_back(v(15, 0, 0, 0, 0, 0,   0, 1, 3'b100));
      vecs.push_back(v( 1, 0, 0, 0, 0, 0,   1, 1, 3'b100));
      vecs.push_back(v( 1, 0, 0, 0, 0, 1,   1, 1, 3'b100));
      vecs.push_back(v( 7, 0, 0, 0, 0, 1,   1, 1, 3'b100));
      vecs.push_back(v( 3, 0, 0, 0, 0, 1,   1, 0, 3'b100));
      // reset in ASSERT cycle 5, then requests during reset are ignored
      vecs.push_back(v( 1, 0, 0, 0, 1, 1,   0, 1, 3'b100));
      vecs.push_back(v( 4, 0, 0, 0, 0, 0,   0, 1, 3'b100));
      vecs.push_back(v( 1, 1, 0, 0, 0, 0,   1, 0, 3'b000));
      vecs.push_back(v( 3, 0, 0, 0, 0, 1,   1, 0, 3'b000));
      vecs.push_back(v( 1, 1, 1, 1, 1, 1,   1, 0, 3'b000));
      vecs.push_back(v( 2, 0, 0, 0, 0, 1,   1, 0, 3'b000));
      // pending wdog from WAIT_DONE is discarded by a reset in HOLDOFF
      vecs.push_back(v( 1, 0, 1, 0, 0, 1,   0, 1, 3'b001));
      vecs.push_back(v(15, 0, 0, 0, 0, 0,   0, 1, 3'b001));
      vecs.push_back(v( 1, 0, 0, 0, 0, 0,   1, 1, 3'b001));
      vecs.push_back(v( 1, 0, 0, 1, 0, 1,   1, 1, 3'b001));
      vecs.push_back(v( 1, 1, 0, 0, 0, 1,   1, 0, 3'b000));
      vecs.push_back(v(12, 0, 0, 0, 0, 1,   1, 0, 3'b000));

      for (int i = 0; i < vecs.size(); i++) begin
         for (int k = 0; k < vecs[i].n; k++) begin
            rst_i      = vecs[i].rst;
            sw_req_i   = vecs[i].sw;
            wdog_req_i = vecs[i].wdog;
            dbg_req_i  = vecs[i].dbg;
            rst_done_i = vecs[i].done;
            step();
            chk_all(i, k, vecs[i].exp_req_n, vecs[i].exp_busy, vecs[i].exp_cause, 1'b0);
         end
      end

      // Release never observed: rst_done_i stays high throughout.
      rst_i = 1'b0; rst_done_i = 1'b1;
      sw_req_i = 1'b1; step(); sw_req_i = 1'b0;
      chk_all(100, 0, 1'b0, 1'b1, 3'b001, 1'b0);
      repeat (15) step();
      chk_all(100, 1, 1'b0, 1'b1, 3'b001, 1'b0);
      step();
      chk_all(100, 2, 1'b1, 1'b1, 3'b001, 1'b0);
`ifdef RST_REQ_GEN_TIMEOUT_EN
      repeat (31) step();
      chk_all(100, 3, 1'b1, 1'b1, 3'b001, 1'b0);
      step();
      chk_all(100, 4, 1'b1, 1'b1, 3'b001, 1'b1);
      repeat (7) step();
      chk_all(100, 5, 1'b1, 1'b1, 3'b001, 1'b1);
      step();
      chk_all(100, 6, 1'b1, 1'b0, 3'b001, 1'b1);
      rst_i = 1'b1; step(); rst_i = 1'b0;
      chk_all(100, 7, 1'b1, 1'b0, 3'b000, 1'b0);
      // Release in the very cycle the timeout expires: no flag.
      sw_req_i = 1'b1; step(); sw_req_i = 1'b0;
      chk_all(101, 0, 1'b0, 1'b1, 3'b001, 1'b0);
      repeat (15) step();
      step();
      repeat (29) step();
      chk_all(101, 1, 1'b1, 1'b1, 3'b001, 1'b0);
      rst_done_i = 1'b0;
      step();
      step();
      chk_all(101, 2, 1'b1, 1'b1, 3'b001, 1'b0);
      rst_done_i = 1'b1;
      step();
      chk_all(101, 3, 1'b1, 1'b1, 3'b001, 1'b0);
      repeat (8) step();
      chk_all(101, 4, 1'b1, 1'b0, 3'b001, 1'b0);
`else
      repeat (60) step();
      chk_all(100, 3, 1'b1, 1'b1, 3'b001, 1'b0);
      rst_done_i = 1'b0; step();
      rst_done_i = 1'b1; step();
      chk_all(100, 4, 1'b1, 1'b1, 3'b001, 1'b0);
      repeat (7) step();
      chk_all(100, 5, 1'b1, 1'b1, 3'b001, 1'b0);
      step();
      chk_all(100, 6, 1'b1, 1'b0, 3'b001, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
